operand_fetch: RTL and testbench

- Initiator-side controller for the 2-read/1-write register file: accepts decoded instructions (rs1/rs2/rd), drives the register file read ports, and aligns the 1-cycle-latency read data.
- Resolves write-back hazards and presents operands to the execute stage through a valid/ready handshake.
- Sits between decode and execute in the core pipeline.

---
 rtl/rf_pkg.sv | 18 +
 rtl/opfetch_bypass_mux.sv | 41 ++++
 rtl/operand_fetch.sv | 164 ++++++++++++++++
 tb/tb_operand_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the operand-select encoding.
// XLEN and IDX_W are set here and used by every block in the operand-fetch slice.
package rf_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;

    // x0 is hardwired to zero and never takes part in forwarding
    localparam logic [IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_WB,
        SEL_BYP,
        SEL_RF
    } op_sel_e;

endpackage

// File: rtl/opfetch_bypass_mux.sv
// Per-operand source select: x0, live write-back, latched bypass, or register file data.
// The top disables forwarding by tying wb_en and byp low.
module opfetch_bypass_mux
    import rf_pkg::*;
(
    input  logic [IDX_W-1:0] rs,
    input  logic             wb_en,
    input  logic [IDX_W-1:0] wb_index,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             byp,
    input  logic [XLEN-1:0]  byp_data,
    input  logic [XLEN-1:0]  rf_data,
    output logic [XLEN-1:0]  op
);

    op_sel_e sel;

    // Priority: x0, then this cycle's write-back, then latched bypass, then RF
    always_comb begin
        sel = SEL_RF;
        if (rs == REG_ZERO) begin
            sel = SEL_ZERO;
        end else if (wb_en && (wb_index == rs)) begin
            sel = SEL_WB;
        end else if (byp) begin
            sel = SEL_BYP;
        end
    end

    // Steer the chosen source onto the operand
    always_comb begin
        op = rf_data;
        unique case (sel)
            SEL_ZERO: op = '0;
            SEL_WB:   op = wb_data;
            SEL_BYP:  op = byp_data;
            SEL_RF:   op = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute. Issues register file reads, holds the
// instruction in a single stage (S1) while the 1-cycle read data arrives, resolves
// write-back hazards and hands operands to execute over valid/ready.
// Optional macro OPFETCH_BYPASS_EN: when defined, write-back hazards are forwarded;
// when undefined, a hazard stalls S1 and re-reads the register file instead.
module operand_fetch
    import rf_pkg::*;
#(
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [IDX_W-1:0] id_rs1,
    input  logic [IDX_W-1:0] id_rs2,
    input  logic [IDX_W-1:0] id_rd,
    input  logic [TAG_W-1:0] id_tag,
    output logic             rf_rd_en1,
    output logic             rf_rd_en2,
    output logic [IDX_W-1:0] rf_rd_index1,
    output logic [IDX_W-1:0] rf_rd_index2,
    input  logic [XLEN-1:0]  rf_rd_data1,
    input  logic [XLEN-1:0]  rf_rd_data2,
    input  logic [IDX_W-1:0] rf_rd_addr1,
    input  logic [IDX_W-1:0] rf_rd_addr2,
    input  logic             wb_en,
    input  logic [IDX_W-1:0] wb_index,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [IDX_W-1:0] ex_rd,
    output logic [TAG_W-1:0] ex_tag,
    output logic             addr_err
);

    logic             s1_valid;
    logic [IDX_W-1:0] s1_rs1, s1_rs2, s1_rd;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_byp1, s1_byp2;
`ifdef OPFETCH_BYPASS_EN
    logic [XLEN-1:0]  s1_bypd1, s1_bypd2;
`endif

    logic cur_hit1, cur_hit2, iss_hit1, iss_hit2;
    logic hazard, accept, transfer, s1_valid_d;

    // Handshake, read issue and hazard detection
    always_comb begin
        cur_hit1 = wb_en && (wb_index != REG_ZERO) && (wb_index == s1_rs1);
        cur_hit2 = wb_en && (wb_index != REG_ZERO) && (wb_index == s1_rs2);
`ifdef OPFETCH_BYPASS_EN
        hazard   = 1'b0;
`else
        // Without forwarding, any write that S1 would have missed forces a re-read
        hazard   = s1_valid && (cur_hit1 || cur_hit2 || s1_byp1 || s1_byp2);
`endif
        ex_valid     = s1_valid && !hazard;
        id_ready     = (!s1_valid || ex_ready) && !hazard;
        accept       = id_valid && id_ready;
        transfer     = ex_valid && ex_ready;
        s1_valid_d   = accept || (s1_valid && !transfer);
        // A stalled S1 re-reads its own sources so the data stays aligned with it
        rf_rd_index1 = id_ready ? id_rs1 : s1_rs1;
        rf_rd_index2 = id_ready ? id_rs2 : s1_rs2;
        rf_rd_en1    = !reset && (accept || s1_valid);
        rf_rd_en2    = !reset && (accept || s1_valid);
        // The RF returns the old value on a same-cycle read/write of one index
        iss_hit1     = wb_en && (wb_index != REG_ZERO) && (wb_index == rf_rd_index1);
        iss_hit2     = wb_en && (wb_index != REG_ZERO) && (wb_index == rf_rd_index2);
        ex_rd        = s1_rd;
        ex_tag       = s1_tag;
    end

    // S1 pipeline register, bypass capture and sticky echo-error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_rd    <= '0;
            s1_tag   <= '0;
            s1_byp1  <= 1'b0;
            s1_byp2  <= 1'b0;
`ifdef OPFETCH_BYPASS_EN
            s1_bypd1 <= '0;
            s1_bypd2 <= '0;
`endif
            addr_err <= 1'b0;
        end else begin
            if (accept) begin
                s1_rs1 <= id_rs1;
                s1_rs2 <= id_rs2;
                s1_rd  <= id_rd;
                s1_tag <= id_tag;
            end else if (transfer) begin
                s1_rs1 <= '0;
                s1_rs2 <= '0;
                s1_rd  <= '0;
                s1_tag <= '0;
            end
            s1_valid <= s1_valid_d;
            // Recomputed every cycle so a stall re-read drops a stale bypass
            s1_byp1  <= s1_valid_d && iss_hit1;
            s1_byp2  <= s1_valid_d && iss_hit2;
`ifdef OPFETCH_BYPASS_EN
            s1_bypd1 <= (s1_valid_d && iss_hit1) ? wb_data : '0;
            s1_bypd2 <= (s1_valid_d && iss_hit2) ? wb_data : '0;
`endif
            if (s1_valid && ((rf_rd_addr1 != s1_rs1) || (rf_rd_addr2 != s1_rs2))) begin
                addr_err <= 1'b1;
            end
        end
    end

`ifdef OPFETCH_BYPASS_EN
    opfetch_bypass_mux u_mux1 (
        .rs       (s1_rs1),
        .wb_en    (wb_en),
        .wb_index (wb_index),
        .wb_data  (wb_data),
        .byp      (s1_byp1),
        .byp_data (s1_bypd1),
        .rf_data  (rf_rd_data1),
        .op       (ex_op1)
    );

    opfetch_bypass_mux u_mux2 (
        .rs       (s1_rs2),
        .wb_en    (wb_en),
        .wb_index (wb_index),
        .wb_data  (wb_data),
        .byp      (s1_byp2),
        .byp_data (s1_bypd2),
        .rf_data  (rf_rd_data2),
        .op       (ex_op2)
    );
`else
    opfetch_bypass_mux u_mux1 (
        .rs       (s1_rs1),
        .wb_en    (1'b0),
        .wb_index (REG_ZERO),
        .wb_data  (wb_data),
        .byp      (1'b0),
        .byp_data ('0),
        .rf_data  (rf_rd_data1),
        .op       (ex_op1)
    );

    opfetch_bypass_mux u_mux2 (
        .rs       (s1_rs2),
        .wb_en    (1'b0),
        .wb_index (REG_ZERO),
        .wb_data  (wb_data),
        .byp      (1'b0),
        .byp_data ('0),
        .rf_data  (rf_rd_data2),
        .op       (ex_op2)
    );
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 2R/1W register file
// (old value returned on same-cycle read/write). Honours OPFETCH_BYPASS_EN.
module tb_operand_fetch;
    import rf_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic             id_ready;
    logic [IDX_W-1:0] id_rs1, id_rs2, id_rd;
    logic [31:0]      id_tag;
    logic             rf_rd_en1, rf_rd_en2;
    logic [IDX_W-1:0] rf_rd_index1, rf_rd_index2;
    logic [XLEN-1:0]  rf_rd_data1, rf_rd_data2;
    logic [IDX_W-1:0] rf_rd_addr1, rf_rd_addr2;
    logic             wb_en;
    logic [IDX_W-1:0] wb_index;
    logic [XLEN-1:0]  wb_data;
    logic             ex_valid;
    logic             ex_ready;
    logic [XLEN-1:0]  ex_op1, ex_op2;
    logic [IDX_W-1:0] ex_rd;
    logic [31:0]      ex_tag;
    logic             addr_err;

    logic             echo_bad;
    logic [XLEN-1:0]  regs [32];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               xfer300 = 0;

    always #5 clk = ~clk;

    operand_fetch #(.TAG_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_tag       (id_tag),
        .rf_rd_en1    (rf_rd_en1),
        .rf_rd_en2    (rf_rd_en2),
        .rf_rd_index1 (rf_rd_index1),
        .rf_rd_index2 (rf_rd_index2),
        .rf_rd_data1  (rf_rd_data1),
        .rf_rd_data2  (rf_rd_data2),
        .rf_rd_addr1  (rf_rd_addr1),
        .rf_rd_addr2  (rf_rd_addr2),
        .wb_en        (wb_en),
        .wb_index     (wb_index),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rd        (ex_rd),
        .ex_tag       (ex_tag),
        .addr_err     (addr_err)
    );

    // Register file model: registered reads see the pre-write contents
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= XLEN'(i);
            rf_rd_data1 <= '0;
            rf_rd_data2 <= '0;
            rf_rd_addr1 <= '0;
            rf_rd_addr2 <= '0;
        end else begin
            if (rf_rd_en1) begin
                rf_rd_data1 <= regs[rf_rd_index1];
                rf_rd_addr1 <= echo_bad ? 5'd4 : rf_rd_index1;
            end
            if (rf_rd_en2) begin
                rf_rd_data2 <= regs[rf_rd_index2];
                rf_rd_addr2 <= rf_rd_index2;
            end
            if (wb_en && (wb_index != 5'd0)) regs[wb_index] <= wb_data;
        end
    end

    // Counts handoffs of the stalled instruction
    always @(posedge clk) begin
        if (ex_valid && ex_ready && (ex_tag == 32'h300)) xfer300 <= xfer300 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] tag);
        id_valid = 1'b1;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_tag   = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int good;
        int rdy;
        reset    = 1'b1;
        id_valid = 1'b0;
        id_rs1   = '0;
        id_rs2   = '0;
        id_rd    = '0;
        id_tag   = '0;
        wb_en    = 1'b0;
        wb_index = '0;
        wb_data  = '0;
        ex_ready = 1'b1;
        echo_bad = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_op1", ex_op1, 0);
        check("rst_ex_op2", ex_op2, 0);
        check("rst_ex_rd_tag", {ex_rd, ex_tag}, 0);
        check("rst_rd_en", {rf_rd_en1, rf_rd_en2}, 0);
        check("rst_addr_err", addr_err, 0);
        reset = 1'b0;

        // Single instruction
        issue(5'd3, 5'd7, 5'd1, 32'h100);
        #1 check("single_id_ready", id_ready, 1);
        check("single_rd_en", {rf_rd_en1, rf_rd_en2}, 2'b11);
        tick();
        id_valid = 1'b0;
        #1;
        check("single_valid", ex_valid, 1);
        check("single_op1", ex_op1, 32'h3);
        check("single_op2", ex_op2, 32'h7);
        check("single_rd_tag", {ex_rd, ex_tag}, {5'd1, 32'h100});
        check("single_id_ready2", id_ready, 1);
        tick();
        check("single_drain", ex_valid, 0);

        // Back-to-back stream, one instruction per cycle
        good = 0;
        rdy  = 0;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) issue(5'(i), 5'(i), 5'(i), 32'(i));
            else id_valid = 1'b0;
            #1;
            if (id_ready) rdy++;
            if (i > 0 && ex_valid && ex_op1 == 32'(i - 1) && ex_op2 == 32'(i - 1)
                && ex_tag == 32'(i - 1)) good++;
            tick();
        end
        check("stream_good", good, 32);
        check("stream_ready", rdy, 33);
        check("stream_drain", ex_valid, 0);

        // Issue-cycle hazard on rs1
        issue(5'd5, 5'd6, 5'd2, 32'h200);
        wb_en    = 1'b1;
        wb_index = 5'd5;
        wb_data  = 32'hA5A5_0005;
        #1 check("haz_id_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        wb_en    = 1'b0;
        #1;
`ifndef OPFETCH_BYPASS_EN
        check("haz_bubble_valid", ex_valid, 0);
        check("haz_bubble_ready", id_ready, 0);
        tick();
`endif
        check("haz_valid", ex_valid, 1);
        check("haz_op1", ex_op1, 32'hA5A5_0005);
        check("haz_op2", ex_op2, 32'h6);
        tick();
        check("haz_drain", ex_valid, 0);

        // Stall with a write to rs2 while held
        issue(5'd2, 5'd9, 5'd4, 32'h300);
        tick();
        issue(5'd1, 5'd1, 5'd5, 32'h301);
        ex_ready = 1'b0;
        wb_en    = 1'b1;
        wb_index = 5'd9;
        wb_data  = 32'h99;
        #1;
        check("stall1_ready", id_ready, 0);
`ifdef OPFETCH_BYPASS_EN
        check("stall1_op2", ex_op2, 32'h99);
`else
        check("stall1_valid", ex_valid, 0);
`endif
        tick();
        wb_en = 1'b0;
        #1;
        check("stall2_ready", id_ready, 0);
`ifdef OPFETCH_BYPASS_EN
        check("stall2_op2", ex_op2, 32'h99);
`else
        check("stall2_valid", ex_valid, 0);
`endif
        tick();
        check("stall3_valid", ex_valid, 1);
        check("stall3_ready", id_ready, 0);
        check("stall3_op2", ex_op2, 32'h99);
        check("stall3_op1_tag", {ex_op1, ex_tag}, {32'h2, 32'h300});
        ex_ready = 1'b1;
        #1 check("stall_release_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        #1;
        check("stall_next_tag", ex_tag, 32'h301);
        check("stall_next_op1", ex_op1, 32'h1);
        tick();
        check("stall_one_xfer", xfer300, 1);
        check("stall_drain", ex_valid, 0);

        // x0 ignores writes to index 0
        issue(5'd0, 5'd3, 5'd6, 32'h400);
        wb_en    = 1'b1;
        wb_index = 5'd0;
        wb_data  = 32'hFFFF_FFFF;
        tick();
        id_valid = 1'b0;
        #1;
        check("x0_valid", ex_valid, 1);
        check("x0_op1", ex_op1, 0);
        check("x0_op2", ex_op2, 32'h3);
        wb_en = 1'b0;
        tick();
        check("pre_echo_addr_err", addr_err, 0);

        // Echo mismatch sets a sticky error
        issue(5'd3, 5'd3, 5'd7, 32'h500);
        echo_bad = 1'b1;
        tick();
        id_valid = 1'b0;
        echo_bad = 1'b0;
        #1 check("echo_not_yet", addr_err, 0);
        tick();
        check("echo_set", addr_err, 1);
        tick();
        tick();
        check("echo_held", addr_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 check("echo_cleared", addr_err, 0);

        // Reset mid-operation drops the in-flight instruction
        issue(5'd4, 5'd4, 5'd8, 32'h600);
        tick();
        id_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1 check("midrst_valid", ex_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
